// File: rtl/bp_cce_pkg.sv
// Shared types for the CCE directory write path: command opcodes, coherence
// states, and the directory entry layout macro.
`ifndef BSG_SAFE_CLOG2
`define BSG_SAFE_CLOG2(x) (((x) == 1) ? 1 : $clog2(x))
`endif

`ifndef BP_COH_BITS
`define BP_COH_BITS 3
`endif

// Entry layout is {tag, state}; state sits in the LSBs of each row slot.
`define DECLARE_BP_CCE_DIR_ENTRY_S(tag_width_mp) \
  typedef struct packed { \
    logic [tag_width_mp-1:0] tag; \
    bp_coh_states_e          state; \
  } bp_cce_dir_entry_s

package bp_cce_pkg;

  typedef enum logic [1:0] {
    e_dir_wr_entry = 2'b00,
    e_dir_wr_state = 2'b01,
    e_dir_inv_way  = 2'b10,
    e_dir_inv_set  = 2'b11
  } bp_cce_dir_wr_op_e;

  typedef enum logic [2:0] {
    e_COH_I = 3'b000,
    e_COH_S = 3'b001,
    e_COH_E = 3'b010,
    e_COH_F = 3'b011,
    e_COH_M = 3'b110,
    e_COH_O = 3'b111
  } bp_coh_states_e;

endpackage

// File: rtl/bp_cce_dir_row_merge.sv
// Combinational merge of one directory command into a two-tag-set row.
// mask_en_p = 1 produces a field mask; otherwise the mask is all-ones.
module bp_cce_dir_row_merge
  import bp_cce_pkg::*;
  #(parameter int assoc_p     = 8,
    parameter int tag_width_p = 28,
    parameter bit mask_en_p   = 1'b0,
    localparam int lg_assoc_lp    = `BSG_SAFE_CLOG2(assoc_p),
    localparam int entry_width_lp = tag_width_p + `BP_COH_BITS,
    localparam int row_width_lp   = 2 * assoc_p * entry_width_lp)
  (input  logic [row_width_lp-1:0] row_i,
   input  logic                    sel_i,
   input  logic [lg_assoc_lp-1:0]  way_i,
   input  logic [1:0]              op_i,
   input  logic [tag_width_p-1:0]  tag_i,
   input  logic [2:0]              state_i,
   output logic [row_width_lp-1:0] row_o,
   output logic [row_width_lp-1:0] mask_o);

  `DECLARE_BP_CCE_DIR_ENTRY_S(tag_width_p);

  bp_coh_states_e new_state;
  assign new_state = (op_i == e_dir_wr_entry || op_i == e_dir_wr_state)
                   ? bp_coh_states_e'(state_i) : e_COH_I;

  for (genvar gi = 0; gi < 2 * assoc_p; gi++) begin : g_entry
    localparam int set_lp = gi / assoc_p;
    localparam int way_lp = gi % assoc_p;

    bp_cce_dir_entry_s old_entry, new_entry;
    logic hit, tag_hit;

    assign old_entry = row_i[gi*entry_width_lp +: entry_width_lp];
    assign hit = (sel_i == 1'(set_lp))
              && ((op_i == e_dir_inv_set) || (way_i == lg_assoc_lp'(way_lp)));
    assign tag_hit = hit && (op_i == e_dir_wr_entry);

    always_comb begin
      new_entry = old_entry;
      if (tag_hit) new_entry.tag = tag_i;
      if (hit) new_entry.state = new_state;
    end

    assign row_o[gi*entry_width_lp +: entry_width_lp] = new_entry;

    if (mask_en_p) begin : g_mask
      assign mask_o[gi*entry_width_lp +: entry_width_lp] =
        {{tag_width_p{tag_hit}}, {`BP_COH_BITS{hit}}};
    end else begin : g_no_mask
      assign mask_o[gi*entry_width_lp +: entry_width_lp] = '1;
    end
  end

endmodule

// File: rtl/bp_cce_dir_entry_writer.sv
// Directory entry writer: read-modify-write of one directory RAM row per command.
// Define BP_CCE_DIR_WMASK_EN for the masked single-write variant (no read).
module bp_cce_dir_entry_writer
  import bp_cce_pkg::*;
  #(parameter int num_way_groups_p   = 64,
    parameter int num_lce_p          = 8,
    parameter int assoc_p            = 8,
    parameter int tag_width_p        = 28,
    parameter int tag_sets_per_row_p = 2,
    localparam int lg_num_way_groups_lp = `BSG_SAFE_CLOG2(num_way_groups_p),
    localparam int lg_num_lce_lp        = `BSG_SAFE_CLOG2(num_lce_p),
    localparam int lg_assoc_lp          = `BSG_SAFE_CLOG2(assoc_p),
    localparam int rows_per_set_lp      = num_lce_p / 2,
    localparam int entry_width_lp       = tag_width_p + `BP_COH_BITS,
    localparam int row_width_lp         = 2 * assoc_p * entry_width_lp,
    localparam int addr_width_lp        = `BSG_SAFE_CLOG2(num_way_groups_p*rows_per_set_lp))
  (input  logic                            clk_i,
   input  logic                            reset_n_i,
   input  logic                            cmd_v_i,
   output logic                            cmd_ready_o,
   input  logic [1:0]                      cmd_op_i,
   input  logic [lg_num_way_groups_lp-1:0] set_i,
   input  logic [lg_num_lce_lp-1:0]        lce_i,
   input  logic [lg_assoc_lp-1:0]          way_i,
   input  logic [tag_width_p-1:0]          tag_i,
   input  logic [2:0]                      state_i,
   output logic                            done_o,
   output logic                            ram_v_o,
   output logic                            ram_w_o,
   output logic [addr_width_lp-1:0]        ram_addr_o,
   output logic [row_width_lp-1:0]         ram_data_o,
   output logic [row_width_lp-1:0]         ram_mask_o,
   input  logic [row_width_lp-1:0]         ram_data_i);

  if (num_lce_p % 2 != 0) begin : g_bad_lce
    $error("num_lce_p must be even");
  end
  if (tag_sets_per_row_p != 2) begin : g_bad_ts
    $error("only two tag sets per row are supported");
  end

  typedef enum logic [1:0] {e_idle, e_rd, e_mod, e_wr} state_e;

  state_e                   state_q, state_d;
  logic                     ready_q, ready_d;
  logic                     ram_v_q, ram_v_d;
  logic                     ram_w_q, ram_w_d;
  logic                     done_q, done_d;
  logic [addr_width_lp-1:0] addr_q, addr_d;
  logic [row_width_lp-1:0]  data_q, data_d;

  logic [addr_width_lp-1:0] cmd_addr;
  logic                     accept;
  logic [row_width_lp-1:0]  merge_row, merge_mask;
  logic [row_width_lp-1:0]  m_row;
  logic                     m_sel;
  logic [lg_assoc_lp-1:0]   m_way;
  logic [1:0]               m_op;
  logic [tag_width_p-1:0]   m_tag;
  logic [2:0]               m_state;

  // Two LCEs share a row, so the row index within a set is lce/2.
  assign cmd_addr = addr_width_lp'(set_i) * addr_width_lp'(rows_per_set_lp)
                  + addr_width_lp'(lce_i >> 1);
  assign accept = cmd_v_i & ready_q;

`ifdef BP_CCE_DIR_WMASK_EN
  logic [row_width_lp-1:0] mask_q, mask_d;

  // Merging into an all-zero row leaves only the new field values.
  assign m_row   = '0;
  assign m_sel   = lce_i[0];
  assign m_way   = way_i;
  assign m_op    = cmd_op_i;
  assign m_tag   = tag_i;
  assign m_state = state_i;
  assign ram_mask_o = mask_q;
`else
  logic                   sel_q, sel_d;
  logic [lg_assoc_lp-1:0] way_q, way_d;
  logic [1:0]             op_q, op_d;
  logic [tag_width_p-1:0] tag_q, tag_d;
  logic [2:0]             coh_q, coh_d;

  assign m_row   = ram_data_i;
  assign m_sel   = sel_q;
  assign m_way   = way_q;
  assign m_op    = op_q;
  assign m_tag   = tag_q;
  assign m_state = coh_q;
  assign ram_mask_o = merge_mask;
`endif

  bp_cce_dir_row_merge #(
`ifdef BP_CCE_DIR_WMASK_EN
    .mask_en_p  (1'b1),
`else
    .mask_en_p  (1'b0),
`endif
    .assoc_p    (assoc_p),
    .tag_width_p(tag_width_p)
  ) u_merge (
    .row_i  (m_row),
    .sel_i  (m_sel),
    .way_i  (m_way),
    .op_i   (m_op),
    .tag_i  (m_tag),
    .state_i(m_state),
    .row_o  (merge_row),
    .mask_o (merge_mask)
  );

  always_comb begin
    state_d = state_q;
    ready_d = ready_q;
    ram_v_d = 1'b0;
    ram_w_d = 1'b0;
    done_d  = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
`ifdef BP_CCE_DIR_WMASK_EN
    mask_d  = mask_q;
`else
    sel_d   = sel_q;
    way_d   = way_q;
    op_d    = op_q;
    tag_d   = tag_q;
    coh_d   = coh_q;
`endif
    unique case (state_q)
      e_idle: begin
        if (accept) begin
          ready_d = 1'b0;
          addr_d  = cmd_addr;
          ram_v_d = 1'b1;
`ifdef BP_CCE_DIR_WMASK_EN
          state_d = e_wr;
          ram_w_d = 1'b1;
          done_d  = 1'b1;
          data_d  = merge_row;
          mask_d  = merge_mask;
`else
          state_d = e_rd;
          sel_d   = lce_i[0];
          way_d   = way_i;
          op_d    = cmd_op_i;
          tag_d   = tag_i;
          coh_d   = state_i;
`endif
        end
      end
      e_rd: state_d = e_mod;
      e_mod: begin
        // Read data for the row is on ram_data_i this cycle.
        state_d = e_wr;
        data_d  = merge_row;
        ram_v_d = 1'b1;
        ram_w_d = 1'b1;
        done_d  = 1'b1;
      end
      e_wr: begin
        state_d = e_idle;
        ready_d = 1'b1;
      end
      default: state_d = e_idle;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= e_idle;
      ready_q <= 1'b1;
      ram_v_q <= 1'b0;
      ram_w_q <= 1'b0;
      done_q  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
`ifdef BP_CCE_DIR_WMASK_EN
      mask_q  <= '0;
`else
      sel_q   <= 1'b0;
      way_q   <= '0;
      op_q    <= '0;
      tag_q   <= '0;
      coh_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      ram_v_q <= ram_v_d;
      ram_w_q <= ram_w_d;
      done_q  <= done_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
`ifdef BP_CCE_DIR_WMASK_EN
      mask_q  <= mask_d;
`else
      sel_q   <= sel_d;
      way_q   <= way_d;
      op_q    <= op_d;
      tag_q   <= tag_d;
      coh_q   <= coh_d;
`endif
    end
  end

  assign cmd_ready_o = ready_q;
  assign ram_v_o     = ram_v_q;
  assign ram_w_o     = ram_w_q;
  assign done_o      = done_q;
  assign ram_addr_o  = addr_q;
  assign ram_data_o  = data_q;

endmodule

// File: tb/tb_bp_cce_dir_entry_writer.sv
// Directed, table-driven bench for bp_cce_dir_entry_writer with a behavioural
// single-port directory RAM.
module tb_bp_cce_dir_entry_writer;
  import bp_cce_pkg::*;

  localparam int ROW_W = 496;
  localparam int ENT_W = 31;

  logic              clk;
  logic              reset_n;
  logic              cmd_v;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [5:0]        set;
  logic [2:0]        lce;
  logic [2:0]        way;
  logic [27:0]       tag;
  logic [2:0]        st;
  logic              done;
  logic              ram_v;
  logic              ram_w;
  logic [7:0]        ram_addr;
  logic [ROW_W-1:0]  ram_wdata;
  logic [ROW_W-1:0]  ram_mask;
  logic [ROW_W-1:0]  ram_rdata;

  int checks;
  int errors;

  bp_cce_dir_entry_writer dut (
    .clk_i      (clk),
    .reset_n_i  (reset_n),
    .cmd_v_i    (cmd_v),
    .cmd_ready_o(cmd_ready),
    .cmd_op_i   (cmd_op),
    .set_i      (set),
    .lce_i      (lce),
    .way_i      (way),
    .tag_i      (tag),
    .state_i    (st),
    .done_o     (done),
    .ram_v_o    (ram_v),
    .ram_w_o    (ram_w),
    .ram_addr_o (ram_addr),
    .ram_data_o (ram_wdata),
    .ram_mask_o (ram_mask),
    .ram_data_i (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every row starts as entries {0x1234560 + index, E}, index 0..15.
  function automatic logic [ROW_W-1:0] pattern_row();
    logic [ROW_W-1:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[i*ENT_W +: ENT_W] = {28'h1234560 + 28'(i), 3'b010};
    return r;
  endfunction

  logic [ROW_W-1:0] mem [0:255];

  always @(posedge clk) begin
    if (!reset_n) begin
      for (int r = 0; r < 256; r++) mem[r] <= pattern_row();
    end else if (ram_v && ram_w) begin
      mem[ram_addr] <= (mem[ram_addr] & ~ram_mask) | (ram_wdata & ram_mask);
    end
    if (ram_v && !ram_w) ram_rdata <= mem[ram_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_row(input string name, input logic [ROW_W-1:0] act, input logic [ROW_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_cmd(input logic [1:0] o, input logic [5:0] s, input logic [2:0] l,
                           input logic [2:0] w, input logic [27:0] t, input logic [2:0] c);
    cmd_v = 1'b1; cmd_op = o; set = s; lce = l; way = w; tag = t; st = c;
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [5:0]  set;
    logic [2:0]  lce;
    logic [2:0]  way;
    logic [27:0] tag;
    logic [2:0]  st;
    logic [7:0]  exp_addr;
    logic        exp_ts;
    logic [7:0]  exp_ways;
    logic        exp_wtag;
    logic [27:0] exp_tag;
    logic [2:0]  exp_st;
  } vec_t;

  // Pattern row with the listed ways of one tag set overwritten.
  function automatic logic [ROW_W-1:0] expect_row(input logic ts, input logic [7:0] ways,
                                                  input logic wtag, input logic [27:0] t,
                                                  input logic [2:0] c);
    logic [ROW_W-1:0] r;
    int idx;
    r = pattern_row();
    for (int w = 0; w < 8; w++) begin
      if (ways[w]) begin
        idx = (ts ? 8 : 0) + w;
        if (wtag) r[idx*ENT_W+3 +: 28] = t;
        r[idx*ENT_W +: 3] = c;
      end
    end
    return r;
  endfunction

  task automatic run_vec(input int n, input vec_t v);
    logic [ROW_W-1:0] exp;
    exp = expect_row(v.exp_ts, v.exp_ways, v.exp_wtag, v.exp_tag, v.exp_st);
    drive_cmd(v.op, v.set, v.lce, v.way, v.tag, v.st);
    @(negedge clk);
    // Scramble inputs while busy; only the accepted values may be used.
    cmd_v = 1'b0; cmd_op = ~v.op; set = ~v.set; lce = ~v.lce; way = ~v.way; tag = ~v.tag; st = ~v.st;
    chk($sformatf("v%0d_rd_vwdr", n), 32'({ram_v, ram_w, done, cmd_ready}), 32'b1000);
    chk($sformatf("v%0d_rd_addr", n), 32'(ram_addr), 32'(v.exp_addr));
    @(negedge clk);
    chk($sformatf("v%0d_mod_vwd", n), 32'({ram_v, ram_w, done}), 32'b000);
    @(negedge clk);
    chk($sformatf("v%0d_wr_vwd", n), 32'({ram_v, ram_w, done}), 32'b111);
    chk($sformatf("v%0d_wr_addr", n), 32'(ram_addr), 32'(v.exp_addr));
    chk_row($sformatf("v%0d_wr_data", n), ram_wdata, exp);
    @(negedge clk);
    chk($sformatf("v%0d_idle_vwdr", n), 32'({ram_v, ram_w, done, cmd_ready}), 32'b0001);
    $display("txn %0d op %0d set %0d lce %0d way %0d -> row %0d", n, v.op, v.set, v.lce, v.way, v.exp_addr);
  endtask

  initial begin
    vec_t vecs [6];
    logic [3:0] exp_seq [8];
    logic [7:0] exp_adr [8];
    logic [ROW_W-1:0] exp_m;
    int seen;

    vecs[0] = '{e_dir_wr_entry, 6'd5,  3'd3, 3'd2, 28'hABCDEF1, 3'b110, 8'd21,  1'b1, 8'h04, 1'b1, 28'hABCDEF1, 3'b110};
    vecs[1] = '{e_dir_wr_state, 6'd0,  3'd2, 3'd7, 28'hFFFFFFF, 3'b001, 8'd1,   1'b0, 8'h80, 1'b0, 28'h0,       3'b001};
    vecs[2] = '{e_dir_inv_set,  6'd9,  3'd4, 3'd3, 28'h7654321, 3'b110, 8'd38,  1'b0, 8'hFF, 1'b0, 28'h0,       3'b000};
    vecs[3] = '{e_dir_inv_way,  6'd63, 3'd7, 3'd0, 28'h0000000, 3'b110, 8'd255, 1'b1, 8'h01, 1'b0, 28'h0,       3'b000};
    vecs[4] = '{e_dir_wr_entry, 6'd1,  3'd0, 3'd7, 28'h0000001, 3'b111, 8'd4,   1'b0, 8'h80, 1'b1, 28'h0000001, 3'b111};
    vecs[5] = '{e_dir_wr_state, 6'd2,  3'd5, 3'd4, 28'h0BADBAD, 3'b011, 8'd10,  1'b1, 8'h10, 1'b0, 28'h0,       3'b011};

    checks = 0; errors = 0;
    reset_n = 1'b0; cmd_v = 1'b0; cmd_op = '0; set = '0; lce = '0; way = '0; tag = '0; st = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_vwd", 32'({ram_v, ram_w, done}), 32'd0);
    chk("rst_addr", 32'(ram_addr), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

`ifdef BP_CCE_DIR_WMASK_EN
    exp_m = '0;
    exp_m[8*ENT_W +: 3] = 3'b111;
    drive_cmd(e_dir_inv_way, 6'd0, 3'd1, 3'd0, 28'h5555555, 3'b110);
    @(negedge clk);
    cmd_v = 1'b0;
    chk("wm_wr_vwdr", 32'({ram_v, ram_w, done, cmd_ready}), 32'b1110);
    chk("wm_wr_addr", 32'(ram_addr), 32'd0);
    chk_row("wm_mask", ram_mask, exp_m);
    chk_row("wm_data", ram_wdata, '0);
    @(negedge clk);
    chk("wm_idle_vwdr", 32'({ram_v, ram_w, done, cmd_ready}), 32'b0001);
    $display("txn wmask inv_way lce 1 way 0 -> row 0");
`else
    chk_row("mask_all_ones", ram_mask, '1);

    // Asynchronous reset between the read and the write: nothing more issues.
    drive_cmd(e_dir_wr_entry, 6'd10, 3'd0, 3'd1, 28'h1111111, 3'b110);
    @(negedge clk);
    cmd_v = 1'b0;
    chk("abort_rd_addr", 32'(ram_addr), 32'd40);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_async_vwdr", 32'({ram_v, ram_w, done, cmd_ready}), 32'b0001);
    chk("abort_async_addr", 32'(ram_addr), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (ram_v || done) seen++;
    end
    chk("abort_no_access", 32'(seen), 32'd0);
    $display("txn abort row 40 by reset");

    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    // Second command held valid from cycle 1; accepted only at cycle 4.
    exp_seq = '{4'b1000, 4'b0000, 4'b1110, 4'b0001, 4'b1000, 4'b0000, 4'b1110, 4'b0001};
    exp_adr = '{8'd12, 8'd0, 8'd12, 8'd0, 8'd15, 8'd0, 8'd15, 8'd0};
    drive_cmd(e_dir_wr_entry, 6'd3, 3'd1, 3'd0, 28'h0000AAA, 3'b110);
    @(negedge clk);
    drive_cmd(e_dir_wr_state, 6'd3, 3'd6, 3'd5, 28'hFFFFFFF, 3'b001);
    for (int c = 0; c < 8; c++) begin
      chk($sformatf("b2b_c%0d_vwdr", c + 1), 32'({ram_v, ram_w, done, cmd_ready}), 32'(exp_seq[c]));
      if (exp_seq[c][3]) chk($sformatf("b2b_c%0d_addr", c + 1), 32'(ram_addr), 32'(exp_adr[c]));
      if (c == 2) chk_row("b2b_a_data", ram_wdata, expect_row(1'b1, 8'h01, 1'b1, 28'h0000AAA, 3'b110));
      if (c == 6) chk_row("b2b_b_data", ram_wdata, expect_row(1'b0, 8'h20, 1'b0, 28'h0, 3'b001));
      if (c == 4) cmd_v = 1'b0;
      @(negedge clk);
    end
    $display("txn b2b rows 12 then 15");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bp_cce_dir_entry_writer.md
Name: bp_cce_dir_entry_writer

Overview:
- Write-side companion to the CCE directory LRU/tag extraction logic.
- Accepts one coherence-directory update command per transaction: write entry, update state, invalidate way, or invalidate an LCE's whole tag set.
- Performs read-modify-write on a single-port synchronous directory RAM row. Each row holds two LCEs' tag sets, each tag set holding assoc_p entries.
- Sits between the CCE directory controller and the directory RAM.

Parameters:
- num_way_groups_p, 64, directory sets; lg_num_way_groups_lp = `BSG_SAFE_CLOG2(num_way_groups_p).
- num_lce_p, 8, LCE count; must be even (elaboration assert).
- assoc_p, 8, ways per LCE tag set.
- tag_width_p, 28, stored tag width.
- tag_sets_per_row_p, 2, tag sets per row; only 2 is supported (assert).
- Derived: rows_per_set_lp = num_lce_p/2; entry_width_lp = tag_width_p + `bp_coh_bits (3); row_width_lp = 2*assoc_p*entry_width_lp; addr_width_lp = `BSG_SAFE_CLOG2(num_way_groups_p*rows_per_set_lp).

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  asynchronous active-low reset.
- cmd_v_i  in  1  command valid.
- cmd_ready_o  out  1  command accept; high only in IDLE.
- cmd_op_i  in  2  00 WR_ENTRY, 01 WR_STATE, 10 INV_WAY, 11 INV_SET.
- set_i  in  lg_num_way_groups_lp  directory set.
- lce_i  in  lg_num_lce_lp  target LCE.
- way_i  in  lg_assoc_lp  target way.
- tag_i  in  tag_width_p  new tag.
- state_i  in  3  new coherence state (bp_coh_states_e).
- done_o  out  1  one-cycle pulse when the write is issued.
- ram_v_o  out  1  RAM access valid.
- ram_w_o  out  1  1 = write, 0 = read.
- ram_addr_o  out  addr_width_lp  RAM row address.
- ram_data_o  out  row_width_lp  write data.
- ram_mask_o  out  row_width_lp  bit write mask; all-ones unless the optional feature is enabled.
- ram_data_i  in  row_width_lp  read data, valid the cycle after a read.

Behaviour:
- Row address = set_i*rows_per_set_lp + (lce_i>>1).
- Tag set select = lce_i[0]. Entry e of tag set s occupies row bits [(s*assoc_p+e)*entry_width_lp +: entry_width_lp].
- Entry layout is {tag, state}, state in the LSBs.
- Reset state: IDLE. All registered outputs are 0 except cmd_ready_o = 1. ram_v_o = 0 and done_o = 0.
- FSM:
  - IDLE: on cmd_v_i & cmd_ready_o, latch op, address, tag-set select, way, tag and state, then go to RD.
  - RD: ram_v_o = 1, ram_w_o = 0, ram_addr_o = latched address; go to MOD.
  - MOD: capture ram_data_i merged per op into a row register; go to WR.
  - WR: ram_v_o = 1, ram_w_o = 1, same address, ram_data_o = merged row, done_o = 1; go to IDLE.
- Merge rules (only the selected tag set changes):
  - WR_ENTRY: replace tag and state.
  - WR_STATE: replace state only; tag retained.
  - INV_WAY: state = e_COH_I; tag retained.
  - INV_SET: every way of the selected tag set gets state = e_COH_I; tags retained.
- Latency: accept at cycle 0, read at cycle 1, write and done_o at cycle 3. Throughput is one command per 4 cycles.
- cmd_v_i while busy is ignored (not latched). Inputs are sampled only at acceptance.
- Reset asserted mid-transaction aborts immediately. No partial write is issued; state returns to IDLE.
- way_i is ignored for INV_SET. tag_i is ignored for every op except WR_ENTRY.

Optional Feature:
- Macro BP_CCE_DIR_WMASK_EN.
- Defined: no read is performed. IDLE goes directly to WR, and the write issues in the cycle after acceptance.
  - ram_mask_o covers only the modified fields: the whole entry for WR_ENTRY; the state bits for WR_STATE and INV_WAY; all state fields of the tag set for INV_SET.
  - ram_data_o carries the new values in those fields and zeros elsewhere.
  - Throughput is one command per 2 cycles.
- Undefined: ram_mask_o is tied to all-ones and the read-modify-write path above is used.

Decomposition:
- bp_cce_pkg: the cmd_op enum (bp_cce_dir_wr_op_e) and the entry struct via `declare_bp_cce_dir_entry_s.
- Sub-module bp_cce_dir_row_merge: combinational. Inputs are row, tag-set select, way, op, tag and state; outputs are the merged row and the mask. Shared by both build variants.

Test Plan:
1. Reset then idle: cmd_ready_o = 1, ram_v_o = 0, done_o = 0. Assert reset_n_i low asynchronously mid-cycle: all outputs clear without a clock edge.
2. WR_ENTRY with set=5, lce=3, way=2, tag=0xABCDEF1, state=M:
   - read of addr 21 at cycle 1;
   - write of addr 21 at cycle 3 with tag set 1, way 2 = {0xABCDEF1, M};
   - all other bits equal the read data.
3. WR_STATE with lce=2, way=7, state=S on a row whose entry holds tag 0x1234567: written entry = {0x1234567, S}; tag set 1 is unchanged.
4. INV_SET with lce=4 on a row pre-filled with all entries E: tag set 0 states all I, tags kept; tag set 1 unchanged.
5. Back-to-back commands: second cmd_v_i held from cycle 1 is accepted only at cycle 4; done_o pulses at cycles 3 and 7; the second read is not issued before the first write.
6. BP_CCE_DIR_WMASK_EN build, INV_WAY with lce=1, way=0: a single write at cycle 1; ram_mask_o has only bits [assoc_p*entry_width_lp +: 3] set.
